reaction_round_ctrl: RTL and testbench

Round sequencer for the reaction-time game on the board. Takes debounced single-cycle button pulses and runs one round: pseudo-random wait, LED bank on, millisecond timing of the response, then result or fault. Drives the 16-bit LED bank and a binary value for the downstream 7-segment display driver. It owns all game timing; the display and debounce blocks stay passive.

---
 rtl/reaction_pkg.sv | 25 ++
 rtl/ms_tick_gen.sv | 34 +++
 rtl/reaction_round_ctrl.sv | 158 +++++++++++++++
 tb/tb_reaction_round_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time round sequencer.
package reaction_pkg;

  localparam int unsigned TIME_W = 14;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWait   = 3'd1,
    StGo     = 3'd2,
    StResult = 3'd3,
    StFault  = 3'd4
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois form of x^16 + x^14 + x^13 + x^11 + 1, right-shifting.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [TIME_W-1:0] DISP_FAULT = 14'd9999;
  localparam logic [TIME_W-1:0] BEST_RESET = DISP_FAULT;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick prescaler: one-cycle tick every CLK_HZ/1000 clocks, restartable via sync_clr.
module ms_tick_gen #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic sync_clr,
  output logic tick
);

  localparam int unsigned Ticks  = (CLK_HZ / 1000 > 1) ? CLK_HZ / 1000 : 1;
  localparam int unsigned CntW   = (Ticks > 1) ? $clog2(Ticks) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Ticks - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (sync_clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reaction_round_ctrl.sv
// Reaction-time game round sequencer: random wait, GO lamp, ms response timing, result/fault.
// Optional best-time tracking and best_ms port enabled by defining REACTION_BEST_EN.
module reaction_round_ctrl
  import reaction_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned TIMEOUT_MS   = 9999
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_p,
  input  logic              clear_p,
  output logic [15:0]       led,
  output logic [TIME_W-1:0] disp_val,
  output logic              fault,
  output logic [2:0]        state_o
`ifdef REACTION_BEST_EN
  ,
  output logic [TIME_W-1:0] best_ms
`endif
);

  localparam logic [TIME_W-1:0] MinDelay   = TIME_W'(MIN_DELAY_MS);
  localparam logic [TIME_W-1:0] TimeoutVal = TIME_W'(TIMEOUT_MS);

  state_e            state_q, state_d;
  logic [15:0]       lfsr_q;
  logic [TIME_W-1:0] delay_q, delay_d;
  logic [TIME_W-1:0] rt_q, rt_d, rt_inc;
  logic [TIME_W-1:0] disp_q, disp_d;
  logic [TIME_W-1:0] delay_load;
  logic [15:0]       led_q, led_d;
  logic              fault_q, fault_d;
  logic              tick, sync_clr;
`ifdef REACTION_BEST_EN
  logic [TIME_W-1:0] best_q, best_d;
`endif

  ms_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_ms_tick_gen (
    .clk     (clk),
    .reset   (reset),
    .sync_clr(sync_clr),
    .tick    (tick)
  );

  assign delay_load = MinDelay + TIME_W'(lfsr_q[11:0]);
  assign rt_inc     = rt_q + TIME_W'(1);

  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    rt_d    = rt_q;
    disp_d  = disp_q;
`ifdef REACTION_BEST_EN
    best_d  = best_q;
`endif
    if (clear_p) begin
      state_d = StIdle;
      disp_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_p) begin
            state_d = StWait;
            delay_d = delay_load;
          end
        end
        StWait: begin
          // A press on the expiry tick is still a false start.
          if (start_p) begin
            state_d = StFault;
            disp_d  = DISP_FAULT;
          end else if (tick) begin
            if (delay_q <= TIME_W'(1)) begin
              state_d = StGo;
              delay_d = '0;
              rt_d    = '0;
            end else begin
              delay_d = delay_q - TIME_W'(1);
            end
          end
        end
        StGo: begin
          if (start_p) begin
            state_d = StResult;
            disp_d  = rt_q;
`ifdef REACTION_BEST_EN
            if (rt_q < best_q) begin
              best_d = rt_q;
            end
`endif
          end else if (tick) begin
            rt_d = rt_inc;
            if (rt_inc >= TimeoutVal) begin
              state_d = StFault;
              disp_d  = DISP_FAULT;
            end
          end
        end
        StResult: begin
          if (start_p) begin
            state_d = StWait;
            delay_d = delay_load;
          end
        end
        StFault: begin
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Restart the ms prescaler so the first tick lands a full ms after entry.
  assign sync_clr = (state_d != state_q) && ((state_d == StWait) || (state_d == StGo));
  assign led_d    = (state_d == StGo) ? 16'hFFFF : 16'h0000;
  assign fault_d  = (state_d == StFault);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      lfsr_q  <= LFSR_SEED;
      delay_q <= '0;
      rt_q    <= '0;
      disp_q  <= '0;
      led_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_next(lfsr_q);
      delay_q <= delay_d;
      rt_q    <= rt_d;
      disp_q  <= disp_d;
      led_q   <= led_d;
      fault_q <= fault_d;
    end
  end

`ifdef REACTION_BEST_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      best_q <= BEST_RESET;
    end else begin
      best_q <= best_d;
    end
  end

  assign best_ms = best_q;
`endif

  assign led      = led_q;
  assign disp_val = disp_q;
  assign fault    = fault_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Directed bench for reaction_round_ctrl at 10 cycles per ms; define REACTION_BEST_EN to cover best_ms.
module tb_reaction_round_ctrl;
  import reaction_pkg::*;

  localparam int unsigned CLK_HZ = 10_000;
  localparam int unsigned MIN_MS = 5;
  localparam int unsigned TO_MS  = 50;
  localparam int CPM = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_p = 1'b0;
  logic        clear_p = 1'b0;
  logic [15:0] led;
  logic [13:0] disp_val;
  logic        fault;
  logic [2:0]  state_o;
`ifdef REACTION_BEST_EN
  logic [13:0] best_ms;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] m_lfsr;

  reaction_round_ctrl #(
    .CLK_HZ      (CLK_HZ),
    .MIN_DELAY_MS(MIN_MS),
    .TIMEOUT_MS  (TO_MS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start_p (start_p),
    .clear_p (clear_p),
    .led     (led),
    .disp_val(disp_val),
    .fault   (fault),
    .state_o (state_o)
`ifdef REACTION_BEST_EN
    ,
    .best_ms (best_ms)
`endif
  );

  always #5 clk = ~clk;

  // Reference LFSR, written bit-by-bit from the polynomial.
  always @(posedge clk or negedge reset) begin
    if (!reset) m_lfsr <= 16'hACE1;
    else m_lfsr <= {m_lfsr[0], m_lfsr[15], m_lfsr[14] ^ m_lfsr[0], m_lfsr[13] ^ m_lfsr[0],
                    m_lfsr[12], m_lfsr[11] ^ m_lfsr[0], m_lfsr[10:1]};
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start_p = 1'b1;
    @(negedge clk);
    start_p = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_p = 1'b1;
    @(negedge clk);
    clear_p = 1'b0;
  endtask

  // Idle until the low LFSR bits are small so the random wait stays short.
  task automatic wait_small_lfsr();
    int n = 0;
    while (m_lfsr[11:0] >= 12'd8 && n < 5000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_to_go(output int exp_cyc, output int got_cyc);
    int n = 0;
    wait_small_lfsr();
    exp_cyc = CPM * (int'(MIN_MS) + int'(m_lfsr[11:0]));
    pulse_start();
    while (led !== 16'hFFFF && n < 2000) begin
      @(negedge clk);
      n++;
    end
    got_cyc = n;
  endtask

  task automatic test_reset();
    cycles(3);
    reset = 1'b1;
    cycles(2);
    n_vec++; if (state_o !== StIdle) begin n_err++; $display("FAIL reset_state: got %0d expected %0d", state_o, StIdle); end
    n_vec++; if (led !== 16'h0) begin n_err++; $display("FAIL reset_led: got %h expected 0000", led); end
    n_vec++; if (disp_val !== 14'd0) begin n_err++; $display("FAIL reset_disp: got %0d expected 0", disp_val); end
    n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b expected 0", fault); end
`ifdef REACTION_BEST_EN
    n_vec++; if (best_ms !== 14'd9999) begin n_err++; $display("FAIL reset_best: got %0d expected 9999", best_ms); end
`endif
  endtask

  task automatic test_normal_round();
    int d_cyc;
    wait_small_lfsr();
    d_cyc = CPM * (int'(MIN_MS) + int'(m_lfsr[11:0]));
    pulse_start();
    n_vec++; if (state_o !== StWait) begin n_err++; $display("FAIL normal_wait: got %0d expected %0d", state_o, StWait); end
    cycles(d_cyc - 1);
    n_vec++; if (state_o !== StWait || led !== 16'h0) begin n_err++; $display("FAIL normal_pre_go: got state %0d led %h expected %0d 0000", state_o, led, StWait); end
    cycles(1);
    n_vec++; if (state_o !== StGo) begin n_err++; $display("FAIL normal_go_state: got %0d expected %0d", state_o, StGo); end
    n_vec++; if (led !== 16'hFFFF) begin n_err++; $display("FAIL normal_go_led: got %h expected ffff", led); end
    cycles(74);
    pulse_start();
    n_vec++; if (state_o !== StResult) begin n_err++; $display("FAIL normal_result_state: got %0d expected %0d", state_o, StResult); end
    n_vec++; if (disp_val !== 14'd7) begin n_err++; $display("FAIL normal_result_disp: got %0d expected 7", disp_val); end
    n_vec++; if (led !== 16'h0 || fault !== 1'b0) begin n_err++; $display("FAIL normal_result_led: got %h/%b expected 0000/0", led, fault); end
    pulse_clear();
    n_vec++; if (state_o !== StIdle || disp_val !== 14'd0) begin n_err++; $display("FAIL normal_clear: got %0d/%0d expected %0d/0", state_o, disp_val, StIdle); end
  endtask

  task automatic test_stop_on_tick();
    int e, g;
    run_to_go(e, g);
    n_vec++; if (g !== e) begin n_err++; $display("FAIL tick_go_latency: got %0d expected %0d", g, e); end
    cycles(29);
    pulse_start();
    n_vec++; if (disp_val !== 14'd2) begin n_err++; $display("FAIL tick_stop_disp: got %0d expected 2", disp_val); end
    pulse_clear();
  endtask

  task automatic test_false_start();
    wait_small_lfsr();
    pulse_start();
    cycles(19);
    pulse_start();
    n_vec++; if (state_o !== StFault) begin n_err++; $display("FAIL false_state: got %0d expected %0d", state_o, StFault); end
    n_vec++; if (fault !== 1'b1 || disp_val !== 14'd9999) begin n_err++; $display("FAIL false_outputs: got %b/%0d expected 1/9999", fault, disp_val); end
    pulse_start();
    n_vec++; if (state_o !== StFault) begin n_err++; $display("FAIL fault_ignores_start: got %0d expected %0d", state_o, StFault); end
    pulse_clear();
    n_vec++; if (state_o !== StIdle || disp_val !== 14'd0 || fault !== 1'b0) begin n_err++; $display("FAIL false_clear: got %0d/%0d/%b expected %0d/0/0", state_o, disp_val, fault, StIdle); end
  endtask

  task automatic test_timeout();
    int e, g;
    run_to_go(e, g);
    n_vec++; if (g !== e) begin n_err++; $display("FAIL timeout_go_latency: got %0d expected %0d", g, e); end
    cycles(CPM * int'(TO_MS) - 1);
    n_vec++; if (state_o !== StGo || led !== 16'hFFFF) begin n_err++; $display("FAIL timeout_early: got %0d/%h expected %0d/ffff", state_o, led, StGo); end
    cycles(1);
    n_vec++; if (state_o !== StFault || disp_val !== 14'd9999) begin n_err++; $display("FAIL timeout_fault: got %0d/%0d expected %0d/9999", state_o, disp_val, StFault); end
    n_vec++; if (fault !== 1'b1 || led !== 16'h0) begin n_err++; $display("FAIL timeout_flags: got %b/%h expected 1/0000", fault, led); end
    pulse_clear();
  endtask

  task automatic test_clear_beats_start();
    int e, g;
    run_to_go(e, g);
    cycles(44);
    pulse_start();
    n_vec++; if (state_o !== StResult || disp_val !== 14'd4) begin n_err++; $display("FAIL both_pre_result: got %0d/%0d expected %0d/4", state_o, disp_val, StResult); end
    start_p = 1'b1;
    clear_p = 1'b1;
    @(negedge clk);
    start_p = 1'b0;
    clear_p = 1'b0;
    n_vec++; if (state_o !== StIdle || disp_val !== 14'd0) begin n_err++; $display("FAIL both_clear_wins: got %0d/%0d expected %0d/0", state_o, disp_val, StIdle); end
  endtask

  task automatic test_reset_mid_round();
    int e, g;
    run_to_go(e, g);
    cycles(74);
    pulse_start();
    run_to_go(e, g);
    n_vec++; if (g !== e) begin n_err++; $display("FAIL rst_second_round: got %0d expected %0d", g, e); end
    cycles(20);
    reset = 1'b0;
    #1;
    n_vec++; if (led !== 16'h0 || disp_val !== 14'd0) begin n_err++; $display("FAIL rst_async_outputs: got %h/%0d expected 0000/0", led, disp_val); end
    n_vec++; if (state_o !== StIdle || fault !== 1'b0) begin n_err++; $display("FAIL rst_async_state: got %0d/%b expected %0d/0", state_o, fault, StIdle); end
    cycles(3);
    reset = 1'b1;
    cycles(1);
    run_to_go(e, g);
    n_vec++; if (g !== e) begin n_err++; $display("FAIL rst_seed_delay: got %0d expected %0d", g, e); end
    pulse_clear();
  endtask

`ifdef REACTION_BEST_EN
  task automatic test_best();
    int e, g;
    run_to_go(e, g);
    cycles(124);
    pulse_start();
    n_vec++; if (best_ms !== 14'd12) begin n_err++; $display("FAIL best_first: got %0d expected 12", best_ms); end
    run_to_go(e, g);
    cycles(74);
    pulse_start();
    run_to_go(e, g);
    cycles(94);
    pulse_start();
    n_vec++; if (disp_val !== 14'd9 || best_ms !== 14'd7) begin n_err++; $display("FAIL best_after_three: got %0d/%0d expected 9/7", disp_val, best_ms); end
    pulse_clear();
    n_vec++; if (best_ms !== 14'd7) begin n_err++; $display("FAIL best_after_clear: got %0d expected 7", best_ms); end
  endtask
`endif

  initial begin
    test_reset();
    test_normal_round();
    test_stop_on_tick();
    test_false_start();
    test_timeout();
    test_clear_beats_start();
    test_reset_mid_round();
`ifdef REACTION_BEST_EN
    test_best();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
